mdu_sequencer: RTL

- Multiply/divide unit and its sequencer for the E stage of the 5-stage pipeline.
- Accepts the decoder's MDUOp/MDU_start pair with the forwarded rs/rt operands.
- Models the fixed-latency busy period (5 cycles for multiply, 10 for divide) and owns the architectural HI/LO registers.
- Exports busy so the hazard unit can stall any MDU-related instruction in D.

---
 rtl/mdu_sequencer_pkg.sv | 32 +++
 rtl/mdu_arith.sv | 70 +++++++
 rtl/mdu_sequencer.sv | 96 +++++++++
 3 files changed

// File: rtl/mdu_sequencer_pkg.sv
// Shared constants for the E-stage multiply/divide unit: MDUOp codes,
// default busy latencies and sequencer state encodings.
package mdu_sequencer_pkg;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // True for the four ops that start a multi-cycle computation.
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator for mult/multu/div/divu.
// A divide by zero returns the current HI/LO so the later commit is a no-op.
module mdu_arith
  import mdu_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] div_b;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] quot_u;
  logic [31:0] rem_u;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // The divisor is forced to 1 for /0 and for MIN/-1 so the dividers never
  // see an undefined case; those results are substituted below.
  assign div_zero = (b == 32'd0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign div_b    = (div_zero || div_ovf) ? 32'd1 : b;

  assign quot_s = $signed(a) / $signed(div_b);
  assign rem_s  = $signed(a) % $signed(div_b);
  assign quot_u = a / div_b;
  assign rem_u  = a % div_b;

  always_comb begin
    res_hi = cur_hi;
    res_lo = cur_lo;
    case (op)
      MDU_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MDU_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MDU_DIV: begin
        if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else if (!div_zero) begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      MDU_DIVU: begin
        if (!div_zero) begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage MDU sequencer: fixed-latency busy window, shadow result registers
// and the architectural HI/LO, committed together when the window closes.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Issue contract: start/mdu_op are accepted only in IDLE with flush low;
  // the hazard unit stalls D on busy, so nothing is issued during RUN and
  // anything that does arrive then is dropped. flush never cancels a RUN.

  mdu_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      hi_sh, lo_sh, hi_sh_nxt, lo_sh_nxt;
  logic [31:0]      hi_nxt, lo_nxt;
  logic [31:0]      res_hi, res_lo;

  mdu_arith u_arith (
    .op     (mdu_op),
    .a      (a),
    .b      (b),
    .cur_hi (hi),
    .cur_lo (lo),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  assign busy = (state == MDU_RUN);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_sh_nxt = hi_sh;
    lo_sh_nxt = lo_sh;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      MDU_IDLE: begin
        if (!flush) begin
          if (start && is_arith_op(mdu_op)) begin
            state_nxt = MDU_RUN;
            cnt_nxt   = is_mult_op(mdu_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            hi_sh_nxt = res_hi;
            lo_sh_nxt = res_lo;
          end else if (mdu_op == MDU_MTHI) begin
            hi_nxt = a;
          end else if (mdu_op == MDU_MTLO) begin
            lo_nxt = a;
          end
        end
      end
      MDU_RUN: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = MDU_IDLE;
          hi_nxt    = hi_sh;
          lo_nxt    = lo_sh;
        end
      end
      default: state_nxt = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MDU_IDLE;
      cnt   <= '0;
      hi_sh <= '0;
      lo_sh <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi_sh <= hi_sh_nxt;
      lo_sh <= lo_sh_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

endmodule
